regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next-generation architectural register file for the pipelined core. It serves NRP combinational read ports and NWP synchronous write ports, and tracks which registers have an outstanding in-flight writer so decode can detect RAW hazards without a separate scoreboard block. Register 0 is hard-wired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = log2(NREGS)
- NRP, 2, number of read ports
- NWP, 2, number of write ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr_i  in  NRP*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data_o  out  NRP*XLEN  packed read data
- rd_busy_o  out  NRP  busy flag of each addressed register
- wr_en_i  in  NWP  per-port write enable
- wr_addr_i  in  NWP*AW  packed write addresses
- wr_data_i  in  NWP*XLEN  packed write data
- iss_valid_i  in  1  an instruction with a destination is issuing this cycle
- iss_rd_i  in  AW  destination register of the issuing instruction
- busy_o  out  NREGS  full busy vector, bit r = register r busy

## Operation
- Storage: NREGS × XLEN registers plus NREGS busy bits.
- Reset clears every register and every busy bit. All outputs read 0 while reset is held.
- Read port k:
  - rd_data_o[k] = 0 when rd_addr_i[k]==0, otherwise the stored value of rd_addr_i[k].
  - rd_busy_o[k] = busy[rd_addr_i[k]].
- Write port j: on the rising edge with wr_en_i[j]=1 and wr_addr_i[j]≠0, reg[wr_addr_i[j]] ← wr_data_i[j]. A write to register 0 is discarded.
- Write collision: when several enabled ports target the same nonzero address, the highest-indexed port wins. No error is flagged.
- Scoreboard clear: each enabled write clears busy[wr_addr_i[j]].
- Scoreboard set: iss_valid_i=1 with iss_rd_i≠0 sets busy[iss_rd_i]. Issue to register 0 is ignored.
- Same-cycle set and clear of the same register: the set wins and the register stays busy, because the new writer is younger.
- Issuing to an already-busy register is legal (WAW). busy stays 1, and the first writeback clears it. Decode must prevent WAW; this block does not count writers.
- busy_o[0] is constant 0.

## Timing
- Reads are combinational, with zero-cycle latency from address to data.
- Writes and scoreboard updates become visible on the rising edge, so reads reflect them from the following cycle. The same-cycle case is governed by the RF_BYPASS_EN option below.
- Asynchronous reset takes effect immediately, mid-cycle. A write or issue presented in the cycle reset deasserts is applied at the next rising edge after deassertion. Nothing is lost or duplicated except state cleared by the reset itself.
- There are no handshakes: writes and issues are accepted unconditionally every cycle.

## Configuration
- RF_BYPASS_EN defined:
  - Each read port forwards same-cycle write data. If any enabled write port j has wr_addr_i[j]==rd_addr_i[k]≠0, rd_data_o[k] = wr_data_i of the highest such j.
  - rd_busy_o[k] is then 0 unless iss_valid_i also targets that register this cycle, in which case it is 1.
  - busy_o is unaffected and stays registered.
- RF_BYPASS_EN undefined:
  - Reads return only stored values, so data written at edge N is visible after edge N.
  - rd_busy_o is purely registered.

## Test plan
- Reset, then read all registers on every port -> data 0, rd_busy_o 0, busy_o 0.
- Write 0xDEADBEEF to r5 via port 0, then read r5 on port 1 the next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- Same cycle: port 0 writes r7=0x11 and port 1 writes r7=0x22 -> r7 reads 0x22.
- Issue r9 -> busy_o[9]=1 next cycle. Writeback r9 together with a new issue of r9 -> busy remains 1. Writeback r9 alone -> busy_o[9]=0.
- With RF_BYPASS_EN: write r3=0xA5A5A5A5 and read r3 in the same cycle -> rd_data_o=0xA5A5A5A5, rd_busy_o=0. Without the macro -> the old value in that cycle and the new value the next cycle.
- Assert reset mid-cycle with r5 holding data and r9 busy -> outputs go to 0 immediately. After deassertion, a write to r5 lands on the next rising edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy scoreboard.
// NRP combinational read ports, NWP synchronous write ports, register 0 hard-wired to zero.
// The busy bits mark registers with an in-flight writer so decode can detect RAW hazards.
// Optional feature macro: RF_BYPASS_EN forwards same-cycle write data (and busy state) to the read ports.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    parameter int NWP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic [NWP-1:0]      wr_en_i,
    input  logic [NWP*AW-1:0]   wr_addr_i,
    input  logic [NWP*XLEN-1:0] wr_data_i,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [NREGS-1:0]    busy_o
);

    // Architectural state
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;

    // Unpacked views of the packed port buses
    logic [AW-1:0]    rd_addr [NRP];
    logic [AW-1:0]    wr_addr [NWP];
    logic [XLEN-1:0]  wr_data [NWP];

    // Per-register write decode: whether any port hits it, and the winning data
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    // Scoreboard next-state terms
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_clr;
    logic [NREGS-1:0] busy_d;

    // Per-read-port intermediate results
    logic [XLEN-1:0]  rd_val  [NRP];
    logic [NRP-1:0]   rd_bsy;

    // Split the packed address/data buses into per-port arrays
    always_comb begin
        for (int k = 0; k < NRP; k++) begin
            rd_addr[k] = rd_addr_i[k*AW +: AW];
        end
        for (int j = 0; j < NWP; j++) begin
            wr_addr[j] = wr_addr_i[j*AW +: AW];
            wr_data[j] = wr_data_i[j*XLEN +: XLEN];
        end
    end

    // Decode writes per register; later ports overwrite earlier ones so the highest index wins
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NWP; j++) begin
                if (r != 0 && wr_en_i[j] && wr_addr[j] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j];
                end
            end
        end
    end

    // Scoreboard next state: issue sets, writeback clears, and a younger issue beats a writeback
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        busy_d   = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_set[r] = iss_valid_i && (iss_rd_i == AW'(r));
            busy_clr[r] = wr_hit[r];
            busy_d[r]   = busy_set[r] | (busy_q[r] & ~busy_clr[r]);
        end
    end

    // Register storage; register 0 is only ever cleared and never read back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value (zero for r0), optionally overridden by a same-cycle write
    always_comb begin
        for (int k = 0; k < NRP; k++) begin
            rd_val[k] = '0;
            rd_bsy[k] = 1'b0;
            if (rd_addr[k] != '0) begin
                rd_val[k] = regs[rd_addr[k]];
                rd_bsy[k] = busy_q[rd_addr[k]];
            end
`ifdef RF_BYPASS_EN
            for (int j = 0; j < NWP; j++) begin
                if (rd_addr[k] != '0 && wr_en_i[j] && wr_addr[j] == rd_addr[k]) begin
                    rd_val[k] = wr_data[j];
                    rd_bsy[k] = iss_valid_i && (iss_rd_i == rd_addr[k]);
                end
            end
`endif
            if (reset) begin
                rd_val[k] = '0;
                rd_bsy[k] = 1'b0;
            end
        end
    end

    // Repack read results onto the output buses
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRP; k++) begin
            rd_data_o[k*XLEN +: XLEN] = rd_val[k];
            rd_busy_o[k]              = rd_bsy[k];
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven directed bench for regfile_mp (default parameters).
// Inputs change on the falling edge; read outputs are checked 1 ns later, i.e. they
// reflect state from the previous rising edge, and the rising edge then commits the vector.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                reset;
    logic [NRP*AW-1:0]   rd_addr_i;
    logic [NRP*XLEN-1:0] rd_data_o;
    logic [NRP-1:0]      rd_busy_o;
    logic [NWP-1:0]      wr_en_i;
    logic [NWP*AW-1:0]   wr_addr_i;
    logic [NWP*XLEN-1:0] wr_data_i;
    logic                iss_valid_i;
    logic [AW-1:0]       iss_rd_i;
    logic [NREGS-1:0]    busy_o;

    int vecCount;
    int missCount;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs [14];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .iss_valid_i(iss_valid_i),
        .iss_rd_i   (iss_rd_i),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        wr_en_i     = v.we;
        wr_addr_i   = {v.wa1, v.wa0};
        wr_data_i   = {v.wd1, v.wd0};
        iss_valid_i = v.iv;
        iss_rd_i    = v.ir;
        rd_addr_i   = {v.ra1, v.ra0};
    endtask

    task automatic setIdle(input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en_i     = '0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        iss_valid_i = 1'b0;
        iss_rd_i    = '0;
        rd_addr_i   = {ra1, ra0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;

        //          we     wa0   wd0           wa1   wd1    iv    ir     ra0    ra1    ed0           ed1           eb0   eb1   ebusy
        vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0,  5'd1,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1]  = '{2'b01, 5'd0, 32'h00001234, 5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{2'b11, 5'd7, 32'h00000011, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd9,  5'd7,  5'd9,  32'h22,       32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4]  = '{2'b01, 5'd9, 32'h00000099, 5'd0, 32'h0, 1'b1, 5'd9,  5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 1'b0, 1'b0, 32'h200};
        vecs[5]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'hAB, 1'b0, 5'd0, 5'd5,  5'd7,  32'hDEADBEEF, 32'h22,       1'b0, 1'b0, 32'h200};
        vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd9,  5'd9,  32'hAB,       32'hAB,       1'b0, 1'b0, 32'h0};
        vecs[7]  = '{2'b01, 5'd12, 32'h0000000C, 5'd0, 32'h0, 1'b1, 5'd0, 5'd1,  5'd9,  32'h0,        32'hAB,       1'b0, 1'b0, 32'h0};
        vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd12, 5'd0,  32'hC,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[9]  = '{2'b11, 5'd1, 32'h00001111, 5'd2, 32'h2222, 1'b0, 5'd0, 5'd9, 5'd12, 32'hAB,       32'hC,        1'b0, 1'b0, 32'h0};
        vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd3,  5'd1,  5'd2,  32'h1111,     32'h2222,     1'b0, 1'b0, 32'h0};
        vecs[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd3,  5'd3,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 32'h8};
        vecs[12] = '{2'b01, 5'd3, 32'h00000005, 5'd0, 32'h0, 1'b0, 5'd0,  5'd1,  5'd2,  32'h1111,     32'h2222,     1'b0, 1'b0, 32'h8};
        vecs[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd3,  32'h5,        32'h5,        1'b0, 1'b0, 32'h0};

        // Reset held: every register reads zero and not busy on both ports
        reset = 1'b1;
        setIdle(5'd0, 5'd0);
        #2;
        for (int r = 0; r < NREGS; r++) begin
            rd_addr_i = {5'(r), 5'(r)};
            #1;
            checkOutput($sformatf("reset_data_p0_r%0d", r), rd_data_o[31:0], 32'h0);
            checkOutput($sformatf("reset_data_p1_r%0d", r), rd_data_o[63:32], 32'h0);
            checkOutput($sformatf("reset_busy_r%0d", r), {30'h0, rd_busy_o}, 32'h0);
        end
        checkOutput("reset_busy_vec", busy_o, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_data_p0", i), rd_data_o[31:0], vecs[i].ed0);
            checkOutput($sformatf("v%0d_data_p1", i), rd_data_o[63:32], vecs[i].ed1);
            checkOutput($sformatf("v%0d_rbusy_p0", i), {31'h0, rd_busy_o[0]}, {31'h0, vecs[i].eb0});
            checkOutput($sformatf("v%0d_rbusy_p1", i), {31'h0, rd_busy_o[1]}, {31'h0, vecs[i].eb1});
            checkOutput($sformatf("v%0d_busy_vec", i), busy_o, vecs[i].ebusy);
        end

        // Same-cycle write and read of r3 (r3 currently holds 0x5)
        @(negedge clk);
        setIdle(5'd3, 5'd3);
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd3};
        wr_data_i = {32'h0, 32'hA5A5A5A5};
        #1;
`ifdef RF_BYPASS_EN
        checkOutput("bypass_same_cycle_data", rd_data_o[31:0], 32'hA5A5A5A5);
`else
        checkOutput("bypass_same_cycle_data", rd_data_o[31:0], 32'h5);
`endif
        checkOutput("bypass_same_cycle_busy", {31'h0, rd_busy_o[0]}, 32'h0);
        @(negedge clk);
        setIdle(5'd3, 5'd3);
        #1;
        checkOutput("bypass_next_cycle_data", rd_data_o[63:32], 32'hA5A5A5A5);

`ifdef RF_BYPASS_EN
        // Forwarded write plus a new issue to the same register reports busy
        @(negedge clk);
        setIdle(5'd3, 5'd0);
        wr_en_i     = 2'b10;
        wr_addr_i   = {5'd3, 5'd0};
        wr_data_i   = {32'h77, 32'h0};
        iss_valid_i = 1'b1;
        iss_rd_i    = 5'd3;
        #1;
        checkOutput("bypass_issue_busy", {31'h0, rd_busy_o[0]}, 32'h1);
        checkOutput("bypass_issue_data", rd_data_o[31:0], 32'h77);
        @(negedge clk);
        setIdle(5'd0, 5'd0);
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd3};
        wr_data_i = {32'h0, 32'hA5A5A5A5};
`endif

        // Mid-cycle asynchronous reset with r5 holding data and r9 busy
        @(negedge clk);
        setIdle(5'd5, 5'd9);
        iss_valid_i = 1'b1;
        iss_rd_i    = 5'd9;
        @(negedge clk);
        setIdle(5'd5, 5'd9);
        #1;
        checkOutput("prereset_r5_data", rd_data_o[31:0], 32'hDEADBEEF);
        checkOutput("prereset_r9_busy", {31'h0, rd_busy_o[1]}, 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_r5_data", rd_data_o[31:0], 32'h0);
        checkOutput("midreset_r9_busy", {31'h0, rd_busy_o[1]}, 32'h0);
        checkOutput("midreset_busy_vec", busy_o, 32'h0);
        @(negedge clk);
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd5};
        wr_data_i = {32'h0, 32'h00000077};
        #1;
        checkOutput("reset_held_write_data", rd_data_o[31:0], 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge_data", rd_data_o[31:0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        setIdle(5'd5, 5'd9);
        #1;
        checkOutput("postreset_r5_data", rd_data_o[31:0], 32'h77);
        checkOutput("postreset_r9_busy", {31'h0, rd_busy_o[1]}, 32'h0);
        checkOutput("postreset_busy_vec", busy_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
